// File: rtl/board_swap_sequencer_if.sv
// Board storage port between the swap sequencer and the gem RAM.
// master: addr/rd_en/wr_en/wdata out, rdata in (valid cycle after rd_en).
interface board_swap_sequencer_if #(
  parameter int CELL_W  = 3,
  parameter int COORD_W = 3
);
  logic [2*COORD_W-1:0] mem_addr;
  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [CELL_W-1:0]    mem_wdata;
  logic [CELL_W-1:0]    mem_rdata;

  modport master (
    output mem_addr,
    output mem_rd_en,
    output mem_wr_en,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    input  mem_wr_en,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/board_swap_sequencer.sv
// Cursor/selection owner and gem swap sequencer for the 8x8 board.
// Ports: clk, game_reset, keys, board_busy, mem bus, cursor/sel, swap result.
module board_swap_sequencer #(
  parameter int CELL_W  = 3,
  parameter int COORD_W = 3
) (
  input  logic                   clk,
  input  logic                   game_reset,
  input  logic                   left,
  input  logic                   right,
  input  logic                   up,
  input  logic                   down,
  input  logic                   enter,
  input  logic                   board_busy,
  board_swap_sequencer_if.master mem,
  output logic [COORD_W-1:0]     cursor_x,
  output logic [COORD_W-1:0]     cursor_y,
  output logic                   sel_valid,
  output logic [COORD_W-1:0]     sel_x,
  output logic [COORD_W-1:0]     sel_y,
  output logic                   busy,
  output logic                   swap_done,
  output logic [2*COORD_W-1:0]   swap_a_addr,
  output logic [2*COORD_W-1:0]   swap_b_addr
);
  localparam int AW = 2 * COORD_W;
  localparam logic [COORD_W-1:0] MAX = '1;
  localparam logic [COORD_W:0] ONE = 1;

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CAP, WR_A, WR_B, DONE
  } state_t;

  state_t state_q, state_d;

  logic [4:0] key_q, key_d, key_edge;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d;
  logic sv_q, sv_d;
  logic [AW-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CELL_W-1:0] va_q, va_d;
  logic [CELL_W-1:0] wdata_q, wdata_d;
  logic rd_q, rd_d, wr_q, wr_d;
  logic done_q, done_d;

  // key order doubles as priority: enter > left > right > up > down
  assign key_d = {enter, left, right, up, down};
  assign key_edge = key_d & ~key_q;

  // widened so MAX+1 cannot alias to 0 (no wrap adjacency)
  logic [COORD_W:0] cxw, cyw, sxw, syw;
  logic same, adj_x, adj_y;
  assign cxw = {1'b0, cx_q};
  assign cyw = {1'b0, cy_q};
  assign sxw = {1'b0, sx_q};
  assign syw = {1'b0, sy_q};
  assign same = (cx_q == sx_q) && (cy_q == sy_q);
  assign adj_x = (cy_q == sy_q) &&
                 ((cxw == sxw + ONE) ||
                  (sxw == cxw + ONE));
  assign adj_y = (cx_q == sx_q) &&
                 ((cyw == syw + ONE) ||
                  (syw == cyw + ONE));

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sv_d    = sv_q;
    a_d     = a_q;
    b_d     = b_q;
    va_d    = va_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!board_busy) begin
          if (key_edge[4]) begin
            if (!sv_q) begin
              sv_d = 1'b1;
              sx_d = cx_q;
              sy_d = cy_q;
            end else if (same) begin
              sv_d = 1'b0;
            end else if (adj_x || adj_y) begin
              a_d     = {sy_q, sx_q};
              b_d     = {cy_q, cx_q};
              addr_d  = {sy_q, sx_q};
              rd_d    = 1'b1;
              state_d = RD_A;
            end else begin
              sx_d = cx_q;
              sy_d = cy_q;
            end
          end else if (key_edge[3]) begin
            if (cx_q != '0) cx_d = cx_q - 1'b1;
          end else if (key_edge[2]) begin
            if (cx_q != MAX) cx_d = cx_q + 1'b1;
          end else if (key_edge[1]) begin
            if (cy_q != '0) cy_d = cy_q - 1'b1;
          end else if (key_edge[0]) begin
            if (cy_q != MAX) cy_d = cy_q + 1'b1;
          end
        end
      end
      RD_A: begin
        rd_d    = 1'b1;
        addr_d  = b_q;
        state_d = RD_B;
      end
      RD_B: begin
        va_d    = mem.mem_rdata;
        state_d = CAP;
      end
      CAP: begin
        // B's data arrives now; it goes straight out as A's write data
        wr_d    = 1'b1;
        addr_d  = a_q;
        wdata_d = mem.mem_rdata;
        state_d = WR_A;
      end
      WR_A: begin
        wr_d    = 1'b1;
        addr_d  = b_q;
        wdata_d = va_q;
        state_d = WR_B;
      end
      WR_B: begin
        done_d  = 1'b1;
        sa_d    = a_q;
        sb_d    = b_q;
        sv_d    = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge game_reset) begin
    if (game_reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      sv_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      va_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sv_q    <= sv_d;
      a_q     <= a_d;
      b_q     <= b_d;
      va_q    <= va_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_rd_en = rd_q;
  assign mem.mem_wr_en = wr_q;
  assign mem.mem_wdata = wdata_q;
  assign cursor_x      = cx_q;
  assign cursor_y      = cy_q;
  assign sel_valid     = sv_q;
  assign sel_x         = sx_q;
  assign sel_y         = sy_q;
  assign busy          = (state_q != IDLE);
  assign swap_done     = done_q;
  assign swap_a_addr   = sa_q;
  assign swap_b_addr   = sb_q;
endmodule

// File: tb/tb_board_swap_sequencer.sv
// Bench for board_swap_sequencer: RAM model, behavioural reference,
// per-cycle compare plus directed literal checks.
module tb_board_swap_sequencer;
  localparam int CW = 3;
  localparam int KW = 3;
  localparam logic [4:0] KE = 5'b10000;
  localparam logic [4:0] KL = 5'b01000;
  localparam logic [4:0] KR = 5'b00100;
  localparam logic [4:0] KU = 5'b00010;
  localparam logic [4:0] KD = 5'b00001;

  logic clk = 1'b0;
  logic game_reset = 1'b1;
  logic board_busy = 1'b0;
  logic mem_init = 1'b1;
  logic [4:0] keys = '0;

  logic [KW-1:0] cursor_x, cursor_y, sel_x, sel_y;
  logic sel_valid, busy, swap_done;
  logic [2*KW-1:0] swap_a_addr, swap_b_addr;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_wr = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  board_swap_sequencer_if #(.CELL_W(CW), .COORD_W(KW)) bus ();

  board_swap_sequencer #(.CELL_W(CW), .COORD_W(KW)) dut (
    .clk(clk),
    .game_reset(game_reset),
    .left(keys[3]),
    .right(keys[2]),
    .up(keys[1]),
    .down(keys[0]),
    .enter(keys[4]),
    .board_busy(board_busy),
    .mem(bus),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .sel_valid(sel_valid),
    .sel_x(sel_x),
    .sel_y(sel_y),
    .busy(busy),
    .swap_done(swap_done),
    .swap_a_addr(swap_a_addr),
    .swap_b_addr(swap_b_addr)
  );

  function automatic logic [CW-1:0] pat(int i);
    return CW'((3 * i + 4) % 5);
  endfunction

  logic [CW-1:0] ram [64];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= pat(i);
    end else if (bus.mem_wr_en) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // reference: cursor/selection rules plus a swap step counter 1..6
  int m_cx, m_cy, m_sx, m_sy, m_sv;
  int m_step, m_a, m_b, m_va, m_vb, m_sa, m_sb;
  int m_board [64];
  logic [4:0] m_prev, e;

  initial begin
    for (int i = 0; i < 64; i++) m_board[i] = int'(pat(i));
    forever begin
      @(posedge clk or posedge game_reset);
      if (game_reset) begin
        m_cx = 0; m_cy = 0; m_sx = 0; m_sy = 0; m_sv = 0;
        m_step = 0; m_sa = 0; m_sb = 0; m_prev = '0;
      end else begin
        e = keys & ~m_prev;
        m_prev = keys;
        if (m_step != 0) begin
          if (m_step == 4) m_board[m_a] = m_vb;
          if (m_step == 5) begin
            m_board[m_b] = m_va;
            m_sv = 0; m_sa = m_a; m_sb = m_b;
          end
          m_step = (m_step == 6) ? 0 : m_step + 1;
        end else if (!board_busy) begin
          if (e[4]) begin
            if (m_sv == 0) begin
              m_sv = 1; m_sx = m_cx; m_sy = m_cy;
            end else if (m_cx == m_sx && m_cy == m_sy) begin
              m_sv = 0;
            end else if (iabs(m_cx - m_sx) + iabs(m_cy - m_sy) == 1) begin
              m_a = m_sy * 8 + m_sx;
              m_b = m_cy * 8 + m_cx;
              m_va = m_board[m_a];
              m_vb = m_board[m_b];
              m_step = 1;
            end else begin
              m_sx = m_cx; m_sy = m_cy;
            end
          end else if (e[3]) m_cx = (m_cx > 0) ? m_cx - 1 : 0;
          else if (e[2]) m_cx = (m_cx < 7) ? m_cx + 1 : 7;
          else if (e[1]) m_cy = (m_cy > 0) ? m_cy - 1 : 0;
          else if (e[0]) m_cy = (m_cy < 7) ? m_cy + 1 : 7;
        end
      end
    end
  end

  initial begin
    int erd, ewr;
    forever begin
      @(posedge clk);
      #1;
      erd = (m_step == 1 || m_step == 2) ? 1 : 0;
      ewr = (m_step == 4 || m_step == 5) ? 1 : 0;
      chk("cursor_x", cursor_x, m_cx);
      chk("cursor_y", cursor_y, m_cy);
      chk("sel_valid", sel_valid, m_sv);
      chk("sel_x", sel_x, m_sx);
      chk("sel_y", sel_y, m_sy);
      chk("busy", busy, (m_step != 0) ? 1 : 0);
      chk("swap_done", swap_done, (m_step == 6) ? 1 : 0);
      chk("swap_a_addr", swap_a_addr, m_sa);
      chk("swap_b_addr", swap_b_addr, m_sb);
      chk("rd_en", bus.mem_rd_en, erd);
      chk("wr_en", bus.mem_wr_en, ewr);
      chk("rd_wr_excl", bus.mem_rd_en & bus.mem_wr_en, 0);
      if (erd != 0)
        chk("rd_addr", bus.mem_addr, (m_step == 1) ? m_a : m_b);
      if (ewr != 0) begin
        chk("wr_addr", bus.mem_addr, (m_step == 4) ? m_a : m_b);
        chk("wdata", bus.mem_wdata, (m_step == 4) ? m_vb : m_va);
      end
      if (bus.mem_rd_en === 1'b1 || bus.mem_wr_en === 1'b1) n_acc++;
      if (bus.mem_wr_en === 1'b1) n_wr++;
      if (swap_done === 1'b1) n_done++;
    end
  end

  task automatic press(input logic [4:0] k);
    @(negedge clk);
    keys = k;
    @(negedge clk);
    keys = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, got, wr0, dn0;
    repeat (3) @(negedge clk);
    game_reset = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    chk("rst_cursor", {cursor_y, cursor_x}, 0);
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_busy", busy, 0);

    repeat (9) press(KR);
    repeat (2) press(KD);
    chk("sat_x", cursor_x, 7);
    chk("down_y", cursor_y, 2);
    chk("move_sel_valid", sel_valid, 0);
    chk("move_no_access", n_acc, 0);

    repeat (4) press(KL);
    press(KE);
    press(KR);
    @(negedge clk);
    keys = KE;
    lat = 0;
    got = 0;
    for (int i = 1; i <= 20 && got == 0; i++) begin
      @(negedge clk);
      keys = '0;
      if (swap_done) begin
        got = 1;
        lat = i;
      end
    end
    chk("swap_latency", lat, 6);
    repeat (2) @(negedge clk);
    chk("swap_a_lit", swap_a_addr, 8'h13);
    chk("swap_b_lit", swap_b_addr, 8'h14);
    chk("ram13_lit", ram[19], 4);
    chk("ram14_lit", ram[20], 1);
    chk("swap_sel_clr", sel_valid, 0);
    chk("done_once", n_done, 1);
    chk("swap_accesses", n_acc, 4);

    repeat (3) press(KL);
    press(KU);
    press(KE);
    repeat (2) press(KR);
    repeat (2) press(KD);
    press(KE);
    chk("relatch_sx", sel_x, 3);
    chk("relatch_sy", sel_y, 3);
    chk("relatch_sv", sel_valid, 1);
    chk("relatch_no_acc", n_acc, 4);
    press(KE);
    chk("deselect_sv", sel_valid, 0);

    board_busy = 1'b1;
    press(KE);
    press(KL);
    chk("bb_cursor_x", cursor_x, 3);
    chk("bb_sel_valid", sel_valid, 0);
    board_busy = 1'b0;
    press(KL);
    chk("bb_after_x", cursor_x, 2);

    repeat (2) press(KL);
    repeat (3) press(KU);
    press(KE | KR);
    chk("simul_sv", sel_valid, 1);
    chk("simul_sel", {sel_y, sel_x}, 0);
    chk("simul_cursor", {cursor_y, cursor_x}, 0);
    press(KD);
    press(KE);
    press(KR);
    press(KL);
    press(KU);
    repeat (4) @(negedge clk);
    chk("during_swap_cur", {cursor_y, cursor_x}, 8'h08);
    chk("done_twice", n_done, 2);
    chk("swap2_b", swap_b_addr, 8);
    chk("ram00_lit", ram[0], 3);
    chk("ram08_lit", ram[8], 4);

    press(KE);
    press(KR);
    @(negedge clk);
    keys = KE;
    got = 0;
    for (int i = 1; i <= 20 && got == 0; i++) begin
      @(negedge clk);
      keys = '0;
      if (bus.mem_wr_en) got = 1;
    end
    chk("reach_wr_a", got, 1);
    wr0 = n_wr;
    dn0 = n_done;
    game_reset = 1'b1;
    @(negedge clk);
    chk("abort_cursor", {cursor_y, cursor_x}, 0);
    chk("abort_sel", {sel_valid, sel_y, sel_x}, 0);
    chk("abort_strobes", {bus.mem_rd_en, bus.mem_wr_en}, 0);
    chk("abort_addr", {bus.mem_addr, bus.mem_wdata}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", swap_done, 0);
    chk("abort_swap", {swap_a_addr, swap_b_addr}, 0);
    repeat (2) @(negedge clk);
    game_reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_wr_b", n_wr, wr0);
    chk("abort_no_done", n_done, dn0);
    chk("ram09_lit", ram[9], 1);

    for (int i = 0; i < 64; i++) chk("board", ram[i], m_board[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/board_swap_sequencer.md
Name: board_swap_sequencer

Overview:
- Owns the player cursor and the two-cell selection on the 8x8 gem board.
- Sequences the actual gem swap through the board's single read/write port.
- Sits between the keypad front end (synchronised, debounced levels) and the board storage.
- Raises a completion pulse carrying both swapped addresses so downstream match logic can re-scan.

Parameters:
CELL_W, 3, width of one board cell (gem code 0..4)
COORD_W, 3, width of one board coordinate (board is 2^COORD_W square)

Ports:
clk  in  1  system clock
game_reset  in  1  asynchronous, active-high reset
left  in  1  level key input, rising edge = one press
right  in  1  level key input
up  in  1  level key input
down  in  1  level key input
enter  in  1  level key input, select/confirm
board_busy  in  1  board fill/refill engine active; key presses ignored while high in IDLE
mem_rdata  in  CELL_W  board read data, valid the cycle after mem_rd_en
mem_addr  out  2*COORD_W  board address {y,x}
mem_rd_en  out  1  board read strobe
mem_wr_en  out  1  board write strobe
mem_wdata  out  CELL_W  board write data
cursor_x  out  COORD_W  cursor column
cursor_y  out  COORD_W  cursor row
sel_valid  out  1  a first cell is selected
sel_x  out  COORD_W  selected column
sel_y  out  COORD_W  selected row
busy  out  1  swap in progress (state != IDLE)
swap_done  out  1  one-cycle pulse at swap completion
swap_a_addr  out  2*COORD_W  {y,x} of first cell, held valid from swap_done until next swap starts
swap_b_addr  out  2*COORD_W  {y,x} of second cell, same validity

Behaviour:
- Reset (game_reset high, asynchronous):
  - All outputs 0: cursor (0,0), sel_valid 0, sel (0,0), swap addrs 0, strobes 0.
  - State goes to IDLE.
  - Key-edge history registers clear to 0, so a key held through reset counts as one press after release.
- Key edges are detected internally, one per rising edge.
- In IDLE with board_busy=0, at most one event is acted on per cycle. Priority: enter > left > right > up > down. Lower-priority simultaneous edges are discarded.
- Edges seen outside IDLE, or while board_busy=1, are discarded, not queued.
- Cursor movement:
  - left decrements x, right increments x, up decrements y, down increments y.
  - Coordinates saturate at 0 and 2^COORD_W-1; no wrap.
  - The cursor moves freely while sel_valid=1.
- Enter with sel_valid=0: latch the cursor into sel, set sel_valid=1.
- Enter with sel_valid=1:
  - Cursor == sel: clear sel_valid (deselect).
  - Cursor orthogonally adjacent to sel (|dx|+|dy|==1, no wrap): A=sel, B=cursor, go to RD_A.
  - Otherwise: re-latch sel to the cursor; sel_valid stays 1.
- Swap FSM, one cycle per state:
  - RD_A: mem_rd_en=1, addr=A.
  - RD_B: mem_rd_en=1, addr=B; capture mem_rdata as val_a.
  - CAP: capture mem_rdata as val_b.
  - WR_A: mem_wr_en=1, addr=A, wdata=val_b.
  - WR_B: mem_wr_en=1, addr=B, wdata=val_a.
  - DONE: swap_done=1, swap_a_addr=A, swap_b_addr=B, sel_valid cleared; go to IDLE.
- Swap latency: 6 cycles from the enter edge being accepted to swap_done.
- busy is high in RD_A..DONE inclusive.
- board_busy is ignored once a swap has started; the fill engine must wait for busy=0.
- mem_rd_en and mem_wr_en are never high together. Outside their states, strobes are 0 and addr/wdata hold their last value.
- game_reset mid-swap aborts immediately: no further writes, no swap_done. A half-written board is acceptable because reset triggers a refill.

Test Plan:
- Reset, then press right 9 times, then down 2 times -> cursor (7,2); x saturates at 7; sel_valid=0; no strobes.
- Board[2][3]=1, board[2][4]=4; enter at (3,2), right, enter -> reads A (0x13) then B (0x14); writes 0x13<=4, 0x14<=1; swap_done high exactly once, 6 cycles after the second enter; swap_a_addr=0x13, swap_b_addr=0x14; sel_valid=0.
- Enter at (1,1), move to (3,3), enter -> no memory access; sel=(3,3), sel_valid=1. Enter again without moving -> sel_valid=0.
- board_busy=1 with enter and left edges -> no change to cursor or sel. Deassert, press left -> cursor moves by exactly one.
- enter and right rising in the same cycle at (0,0) -> selection made, cursor stays (0,0). Key edges during a swap -> ignored; cursor unchanged after DONE.
- Assert game_reset during WR_A -> WR_B never occurs, swap_done stays 0; all outputs 0 next cycle; state IDLE.
